id_exe_reg: RTL and testbench
=============================

ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of PC and register-value fields.
REQ-002 Parameter REG_AW, default 4, width of register-number fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  branch taken; insert bubble at next edge.
REQ-006 freeze  input  1  hazard stall; hold all outputs at next edge.
REQ-007 valid_in / valid_out  input / output  1  instruction present in ID / EXE.
REQ-008 pc_in / pc_out  input / output  DATA_W  PC+4 of instruction.
REQ-009 val_rn_in / val_rn_out  input / output  DATA_W  Rn operand value.
REQ-010 val_rm_in / val_rm_out  input / output  DATA_W  Rm value for the Val2 generator.
REQ-011 shift_operand_in / shift_operand_out  input / output  12  shifter/offset field for the Val2 generator.
REQ-012 imm_in / imm_out  input / output  1  I bit for the Val2 generator.
REQ-013 signed_imm24_in / signed_imm24_out  input / output  24  branch offset.
REQ-014 exe_cmd_in / exe_cmd_out  input / output  4  ALU command.
REQ-015 mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  input  1 each  control bits; matching *_out outputs, 1 each.
REQ-016 dest_in, src1_in, src2_in  input  REG_AW each  register numbers; matching *_out outputs, for writeback and forwarding.
REQ-017 status_c_in / status_c_out  input / output  1  carry flag sampled in ID.

Function
REQ-018 Edge priority SHALL be: rst > flush > freeze > load.
REQ-019 Load: with flush=0, freeze=0, every *_out SHALL equal its *_in one cycle after the edge (latency 1).
REQ-020 Freeze: with flush=0, freeze=1, every output SHALL keep its previous value.
REQ-021 Flush: valid_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out and s_out SHALL clear to 0 regardless of freeze; data fields SHALL clear to 0.
REQ-022 valid_in=0 with load SHALL load all control bits as 0 (bubble) and load data fields as presented.
REQ-023 Outputs SHALL be driven directly from flops with no combinational path from any input.
REQ-024 mem_r_en_out and mem_w_en_out SHALL never both be 1; if both inputs are 1 at a load edge, both outputs SHALL load as 0.
REQ-025 No field SHALL be transformed, sign-extended or truncated; widths SHALL pass through unchanged.

Reset
REQ-026 rst=1 SHALL clear every output to 0 immediately, independent of clk.
REQ-027 Reset during freeze or flush SHALL still clear all outputs; the first load SHALL occur on the first rising edge with rst=0.

Structure
REQ-028 Field widths, EXE_CMD encodings and the bubble constant SHALL reside in shared package arm_pkg.
REQ-029 Storage SHALL use one parameterised sub-module pipe_reg (width, enable, synchronous clear, async reset), instantiated per field group.

Verification
REQ-030 Load: pc_in=0x00000010, val_rm_in=0x80000001, shift_operand_in=0x0E3, imm_in=0 -> next cycle outputs equal inputs, valid_out=1.
REQ-031 Freeze: load wb_en_in=1, dest_in=3, then freeze=1 for 3 cycles with dest_in=7 -> dest_out stays 3, wb_en_out stays 1; after release dest_out=7.
REQ-032 Flush+freeze same edge: wb_en_in=1, mem_w_en_in=1, flush=1, freeze=1 -> valid_out=0, wb_en_out=0, mem_w_en_out=0, val_rn_out=0.
REQ-033 Async reset: rst asserted mid-cycle with outputs nonzero -> all outputs 0 before next edge; release, then first edge loads inputs.
REQ-034 Illegal control: mem_r_en_in=1, mem_w_en_in=1 -> both outputs 0 next cycle.
REQ-035 Bubble: valid_in=0, wb_en_in=1, s_in=1 -> valid_out=0, wb_en_out=0, s_out=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: field widths, ALU command encodings and the
// control-bundle layout that moves from ID to EXE.
package arm_pkg;

    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;
    localparam int EXE_CMD_W  = 4;

    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;

    typedef struct packed {
        logic valid;
        logic mem_r_en;
        logic mem_w_en;
        logic wb_en;
        logic b;
        logic s;
    } ctrl_t;

    localparam int    CTRL_W      = $bits(ctrl_t);
    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(6'b000000);

    // An empty slot carries no side effects, and a simultaneous read+write
    // request is treated as corrupt and dropped rather than guessed at.
    function automatic ctrl_t sanitize_ctrl(input ctrl_t c);
        ctrl_t r;
        if (!c.valid) begin
            r = CTRL_BUBBLE;
        end else begin
            r = c;
            if (c.mem_r_en && c.mem_w_en) begin
                r.mem_r_en = 1'b0;
                r.mem_w_en = 1'b0;
            end else begin
                r.mem_r_en = c.mem_r_en;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/id_exe_reg_if.sv
// ID->EXE pipeline bundle: stage-register inputs, outputs and the flush/freeze
// controls. The ID/hazard side is master, the pipeline register is slave.
interface id_exe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    import arm_pkg::*;

    logic                  flush;
    logic                  freeze;

    logic                  valid_in,         valid_out;
    logic [DATA_W-1:0]     pc_in,            pc_out;
    logic [DATA_W-1:0]     val_rn_in,        val_rn_out;
    logic [DATA_W-1:0]     val_rm_in,        val_rm_out;
    logic [SHIFT_OP_W-1:0] shift_operand_in, shift_operand_out;
    logic                  imm_in,           imm_out;
    logic [IMM24_W-1:0]    signed_imm24_in,  signed_imm24_out;
    logic [EXE_CMD_W-1:0]  exe_cmd_in,       exe_cmd_out;
    logic                  mem_r_en_in,      mem_r_en_out;
    logic                  mem_w_en_in,      mem_w_en_out;
    logic                  wb_en_in,         wb_en_out;
    logic                  b_in,             b_out;
    logic                  s_in,             s_out;
    logic [REG_AW-1:0]     dest_in,          dest_out;
    logic [REG_AW-1:0]     src1_in,          src1_out;
    logic [REG_AW-1:0]     src2_in,          src2_out;
    logic                  status_c_in,      status_c_out;

    modport master (
        output flush, freeze,
        output valid_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, imm_in,
               signed_imm24_in, exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
               b_in, s_in, dest_in, src1_in, src2_in, status_c_in,
        input  valid_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out,
               signed_imm24_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
               b_out, s_out, dest_out, src1_out, src2_out, status_c_out
    );

    modport slave (
        input  flush, freeze,
        input  valid_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, imm_in,
               signed_imm24_in, exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in,
               b_in, s_in, dest_in, src1_in, src2_in, status_c_in,
        output valid_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out,
               signed_imm24_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
               b_out, s_out, dest_out, src1_out, src2_out, status_c_out
    );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline storage element: async reset, then synchronous clear,
// then load-enable; otherwise holds.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Priority: reset > clear > enable > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: flush inserts a bubble, freeze holds the stage,
// and every output comes straight from a flop.
module id_exe_reg
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    id_exe_reg_if.slave  bus
);

    localparam int OPER_W  = 3 * DATA_W;
    localparam int INSTR_W = SHIFT_OP_W + 1 + IMM24_W + EXE_CMD_W + 1;
    localparam int REGS_W  = 3 * REG_AW;

    ctrl_t              ctrl_raw_s;
    ctrl_t              ctrl_d_s;
    ctrl_t              ctrl_q_r;
    logic [OPER_W-1:0]  oper_q_r;
    logic [INSTR_W-1:0] instr_q_r;
    logic [REGS_W-1:0]  regs_q_r;
    logic               load_en_s;

    assign load_en_s  = ~bus.freeze;
    assign ctrl_raw_s = '{valid:    bus.valid_in,
                          mem_r_en: bus.mem_r_en_in,
                          mem_w_en: bus.mem_w_en_in,
                          wb_en:    bus.wb_en_in,
                          b:        bus.b_in,
                          s:        bus.s_in};
    assign ctrl_d_s   = sanitize_ctrl(ctrl_raw_s);

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk (clk), .rst (rst), .en (load_en_s), .clr (bus.flush),
        .d   (ctrl_d_s),
        .q   (ctrl_q_r)
    );

    pipe_reg #(.W(OPER_W)) u_oper (
        .clk (clk), .rst (rst), .en (load_en_s), .clr (bus.flush),
        .d   ({bus.pc_in, bus.val_rn_in, bus.val_rm_in}),
        .q   (oper_q_r)
    );

    pipe_reg #(.W(INSTR_W)) u_instr (
        .clk (clk), .rst (rst), .en (load_en_s), .clr (bus.flush),
        .d   ({bus.shift_operand_in, bus.imm_in, bus.signed_imm24_in,
               bus.exe_cmd_in, bus.status_c_in}),
        .q   (instr_q_r)
    );

    pipe_reg #(.W(REGS_W)) u_regs (
        .clk (clk), .rst (rst), .en (load_en_s), .clr (bus.flush),
        .d   ({bus.dest_in, bus.src1_in, bus.src2_in}),
        .q   (regs_q_r)
    );

    assign bus.valid_out    = ctrl_q_r.valid;
    assign bus.mem_r_en_out = ctrl_q_r.mem_r_en;
    assign bus.mem_w_en_out = ctrl_q_r.mem_w_en;
    assign bus.wb_en_out    = ctrl_q_r.wb_en;
    assign bus.b_out        = ctrl_q_r.b;
    assign bus.s_out        = ctrl_q_r.s;

    assign {bus.pc_out, bus.val_rn_out, bus.val_rm_out} = oper_q_r;
    assign {bus.shift_operand_out, bus.imm_out, bus.signed_imm24_out,
            bus.exe_cmd_out, bus.status_c_out} = instr_q_r;
    assign {bus.dest_out, bus.src1_out, bus.src2_out} = regs_q_r;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: reset, load, freeze, flush, bubble,
// illegal memory control and asynchronous reset.
module tb_id_exe_reg;
    import arm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    id_exe_reg_if #(.DATA_W(32), .REG_AW(4)) ifc ();

    id_exe_reg #(.DATA_W(32), .REG_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    logic any_out_s;
    assign any_out_s = |{ifc.valid_out, ifc.pc_out, ifc.val_rn_out, ifc.val_rm_out,
                         ifc.shift_operand_out, ifc.imm_out, ifc.signed_imm24_out,
                         ifc.exe_cmd_out, ifc.mem_r_en_out, ifc.mem_w_en_out,
                         ifc.wb_en_out, ifc.b_out, ifc.s_out, ifc.dest_out,
                         ifc.src1_out, ifc.src2_out, ifc.status_c_out};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_base();
        ifc.flush            = 1'b0;
        ifc.freeze           = 1'b0;
        ifc.valid_in         = 1'b1;
        ifc.pc_in            = 32'h0000_0010;
        ifc.val_rn_in        = 32'h1234_5678;
        ifc.val_rm_in        = 32'h8000_0001;
        ifc.shift_operand_in = 12'h0E3;
        ifc.imm_in           = 1'b0;
        ifc.signed_imm24_in  = 24'hABCDEF;
        ifc.exe_cmd_in       = EXE_ADD;
        ifc.mem_r_en_in      = 1'b1;
        ifc.mem_w_en_in      = 1'b0;
        ifc.wb_en_in         = 1'b1;
        ifc.b_in             = 1'b0;
        ifc.s_in             = 1'b1;
        ifc.dest_in          = 4'd5;
        ifc.src1_in          = 4'd2;
        ifc.src2_in          = 4'd9;
        ifc.status_c_in      = 1'b1;
    endtask

    initial begin
        set_base();
        #1;
        check("reset_all_zero", 64'(any_out_s), 64'd0);
        tick();
        check("reset_held_over_edge", 64'(any_out_s), 64'd0);

        // First load after reset release
        rst = 1'b0;
        tick();
        check("load_valid", 64'(ifc.valid_out), 64'd1);
        check("load_pc", 64'(ifc.pc_out), 64'h10);
        check("load_val_rn", 64'(ifc.val_rn_out), 64'h1234_5678);
        check("load_val_rm", 64'(ifc.val_rm_out), 64'h8000_0001);
        check("load_shift", 64'(ifc.shift_operand_out), 64'h0E3);
        check("load_imm", 64'(ifc.imm_out), 64'd0);
        check("load_imm24", 64'(ifc.signed_imm24_out), 64'hABCDEF);
        check("load_exe_cmd", 64'(ifc.exe_cmd_out), 64'h2);
        check("load_mem_r", 64'(ifc.mem_r_en_out), 64'd1);
        check("load_mem_w", 64'(ifc.mem_w_en_out), 64'd0);
        check("load_wb_s_b", 64'({ifc.wb_en_out, ifc.s_out, ifc.b_out}), 64'b110);
        check("load_regs", 64'({ifc.dest_out, ifc.src1_out, ifc.src2_out}), 64'h529);
        check("load_status_c", 64'(ifc.status_c_out), 64'd1);

        // Inputs change between edges: outputs must not follow combinationally
        ifc.pc_in       = 32'hDEAD_BEEF;
        ifc.imm_in      = 1'b1;
        ifc.b_in        = 1'b1;
        ifc.mem_r_en_in = 1'b0;
        ifc.mem_w_en_in = 1'b1;
        #2;
        check("no_comb_pc", 64'(ifc.pc_out), 64'h10);
        check("no_comb_b", 64'(ifc.b_out), 64'd0);
        tick();
        check("load2_pc", 64'(ifc.pc_out), 64'hDEAD_BEEF);
        check("load2_imm_b", 64'({ifc.imm_out, ifc.b_out}), 64'b11);
        check("load2_mem_w_only", 64'({ifc.mem_r_en_out, ifc.mem_w_en_out}), 64'b01);

        // Freeze holds dest=3 for three edges
        set_base();
        ifc.dest_in = 4'd3;
        tick();
        check("pre_freeze_dest", 64'(ifc.dest_out), 64'd3);
        ifc.freeze  = 1'b1;
        ifc.dest_in = 4'd7;
        ifc.pc_in   = 32'h0000_0044;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_dest", 64'(ifc.dest_out), 64'd3);
            check("freeze_wb", 64'(ifc.wb_en_out), 64'd1);
            check("freeze_pc", 64'(ifc.pc_out), 64'h10);
        end
        ifc.freeze = 1'b0;
        tick();
        check("unfreeze_dest", 64'(ifc.dest_out), 64'd7);
        check("unfreeze_pc", 64'(ifc.pc_out), 64'h44);

        // Flush wins over freeze on the same edge
        ifc.wb_en_in    = 1'b1;
        ifc.mem_r_en_in = 1'b0;
        ifc.mem_w_en_in = 1'b1;
        ifc.flush       = 1'b1;
        ifc.freeze      = 1'b1;
        tick();
        check("flush_valid", 64'(ifc.valid_out), 64'd0);
        check("flush_wb", 64'(ifc.wb_en_out), 64'd0);
        check("flush_mem_w", 64'(ifc.mem_w_en_out), 64'd0);
        check("flush_val_rn", 64'(ifc.val_rn_out), 64'd0);
        check("flush_all_zero", 64'(any_out_s), 64'd0);

        // Both memory enables requested: both dropped, rest loads
        set_base();
        ifc.mem_w_en_in = 1'b1;
        tick();
        check("illegal_mem_rw", 64'({ifc.mem_r_en_out, ifc.mem_w_en_out}), 64'b00);
        check("illegal_valid_wb", 64'({ifc.valid_out, ifc.wb_en_out}), 64'b11);

        // Bubble: control cleared, data passes
        set_base();
        ifc.valid_in = 1'b0;
        ifc.b_in     = 1'b1;
        ifc.pc_in    = 32'h0000_0080;
        tick();
        check("bubble_ctrl", 64'({ifc.valid_out, ifc.mem_r_en_out, ifc.mem_w_en_out,
                                  ifc.wb_en_out, ifc.b_out, ifc.s_out}), 64'd0);
        check("bubble_pc", 64'(ifc.pc_out), 64'h80);
        check("bubble_regs", 64'({ifc.dest_out, ifc.src1_out, ifc.src2_out}), 64'h529);

        // Asynchronous reset mid-cycle, during freeze and flush
        set_base();
        tick();
        check("pre_rst_nonzero", 64'(any_out_s), 64'd1);
        #2;
        rst          = 1'b1;
        ifc.freeze   = 1'b1;
        ifc.flush    = 1'b1;
        #1;
        check("async_rst_zero", 64'(any_out_s), 64'd0);
        tick();
        check("rst_hold_zero", 64'(any_out_s), 64'd0);
        set_base();
        ifc.pc_in = 32'h0000_0100;
        rst       = 1'b0;
        tick();
        check("post_rst_pc", 64'(ifc.pc_out), 64'h100);
        check("post_rst_valid", 64'(ifc.valid_out), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
